// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite channel types and response codes
package axi4_lite_pkg;
    typedef logic [31:0] axi_lite_addr_t;
    typedef logic [31:0] axi_lite_data_t;
    typedef logic [3:0]  axi_lite_strb_t;
    typedef logic [1:0]  axi_lite_resp_t;
    localparam axi_lite_resp_t AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/uart_16550_regs_pkg.sv
// uart_16550_regs_pkg: 16550 register file layout, addresses and ISR codes
package uart_16550_regs_pkg;
    localparam int DL_W  = 16;
    localparam int PSD_W = 4;
    typedef struct packed {
        logic [7:0]       ier;
        logic [7:0]       fcr;
        logic [7:0]       lcr;
        logic [7:0]       mcr;
        logic [7:0]       spr;
        logic [DL_W-1:0]  dl;
        logic [PSD_W-1:0] psd;
    } uart_16550_regs_t;
    localparam logic [2:0] ADDR_RHR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER     = 3'd1;
    localparam logic [2:0] ADDR_ISR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_MSR     = 3'd6;
    localparam logic [2:0] ADDR_SPR     = 3'd7;
    localparam logic [4:0] ISR_LS   = 5'h0C;
    localparam logic [4:0] ISR_RX   = 5'h08;
    localparam logic [4:0] ISR_TX   = 5'h04;
    localparam logic [4:0] ISR_NONE = 5'h03;
endpackage

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: level-sensitive interrupt sources and ISR priority encoding
module uart_irq_ctrl
    import uart_16550_regs_pkg::*;
(
    input  logic [2:0] ier,
    input  logic       rx_ready,
    input  logic       tx_ready,
    input  logic       parity_err,
    input  logic       framing_err,
    input  logic       overrun_err,
    output logic       irq,
    output logic [4:0] code
);
    logic ls, rx, tx;
    // sources follow the live inputs; line status outranks RX, RX outranks TX
    always_comb begin
        ls   = ier[2] & (parity_err | framing_err | overrun_err);
        rx   = ier[0] & rx_ready;
        tx   = ier[1] & tx_ready;
        irq  = ls | rx | tx;
        code = ls ? ISR_LS : rx ? ISR_RX : tx ? ISR_TX : ISR_NONE;
    end
endmodule

// File: rtl/axi_ui.sv
// axi_ui: AXI4-Lite slave exposing a 16550-style UART register file
module axi_ui
    import axi4_lite_pkg::*, uart_16550_regs_pkg::*;
#(
    parameter int DL_WIDTH   = 16,
    parameter int PSD_WIDTH  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  axi_lite_addr_t   awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  axi_lite_data_t   wdata,
    input  axi_lite_strb_t   wstrb,
    input  logic             wvalid,
    output logic             wready,
    output logic             bvalid,
    output axi_lite_resp_t   bresp,
    input  logic             bready,
    input  axi_lite_addr_t   araddr,
    input  logic             arvalid,
    output logic             arready,
    output axi_lite_data_t   rdata,
    output axi_lite_resp_t   rresp,
    output logic             rvalid,
    input  logic             rready,
    output uart_16550_regs_t regs_out,
    output logic             wr_en,
    output logic             rd_en,
    input  logic [7:0]       rd_data,
    input  logic             tx_ready,
    input  logic             rx_ready,
    input  logic             parity_err,
    input  logic             framing_err,
    input  logic             overrun_err,
    output logic             new_baud,
    output logic             irq,
    output logic             irq_n
);
    if (DL_WIDTH != DL_W || PSD_WIDTH != PSD_W || FIFO_DEPTH < 1) begin : g_param_check
        $error("axi_ui: DL_WIDTH/PSD_WIDTH must match uart_16550_regs_pkg");
    end

    uart_16550_regs_t regs;
    logic             aw_acc, ar_acc, wr_commit, dlab;
    logic [4:0]       isr_code;
    logic [7:0]       rbyte;
    logic             unused_bits;

    assign unused_bits = &{1'b0, awaddr[31:3], araddr[31:3], wdata[31:8], wstrb[3:1]};
    assign dlab      = regs.lcr[7];
    assign aw_acc    = rst & awvalid & wvalid & ~bvalid;
    assign ar_acc    = rst & arvalid & ~rvalid;
    assign wr_commit = aw_acc & wstrb[0];
    assign awready   = aw_acc;
    assign wready    = aw_acc;
    assign arready   = ar_acc;
    assign bresp     = AXI_RESP_OKAY;
    assign rresp     = AXI_RESP_OKAY;
    assign regs_out  = regs;
    assign irq_n     = ~irq;

    uart_irq_ctrl u_irq (
        .ier         (regs.ier[2:0]),
        .rx_ready    (rx_ready),
        .tx_ready    (tx_ready),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .irq         (irq),
        .code        (isr_code)
    );

    // register write port; the divisor latch shadows THR/IER while DLAB is set
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '{ier: 8'h00, fcr: 8'h00, lcr: 8'h03, mcr: 8'h00, spr: 8'h00,
                      dl: 16'h0001, psd: '0};
        end else if (wr_commit) begin
            case (awaddr[2:0])
                ADDR_RHR_THR: if (dlab) regs.dl[7:0] <= wdata[7:0];
                ADDR_IER:     if (dlab) regs.dl[15:8] <= wdata[7:0];
                              else regs.ier <= {5'b0, wdata[2:0]};
                ADDR_ISR_FCR: regs.fcr <= wdata[7:0];
                ADDR_LCR:     regs.lcr <= wdata[7:0];
                ADDR_MCR:     regs.mcr <= wdata[7:0];
                ADDR_SPR:     regs.spr <= wdata[7:0];
                default: ;
            endcase
        end
    end

    // read mux; LSR and ISR are built from live line inputs
    always_comb begin
        case (araddr[2:0])
            ADDR_RHR_THR: rbyte = dlab ? regs.dl[7:0] : rd_data;
            ADDR_IER:     rbyte = dlab ? regs.dl[15:8] : regs.ier;
            ADDR_ISR_FCR: rbyte = {3'b000, isr_code};
            ADDR_LCR:     rbyte = regs.lcr;
            ADDR_MCR:     rbyte = regs.mcr;
            ADDR_LSR:     rbyte = {1'b0, tx_ready, tx_ready, 1'b0,
                                   framing_err, parity_err, overrun_err, rx_ready};
            ADDR_MSR:     rbyte = 8'h00;
            default:      rbyte = regs.spr;
        endcase
    end

    // write response channel and the strobes that line up with the first bvalid cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            bvalid   <= 1'b0;
            wr_en    <= 1'b0;
            new_baud <= 1'b0;
        end else begin
            bvalid   <= aw_acc | (bvalid & ~bready);
            wr_en    <= wr_commit & (awaddr[2:0] == ADDR_RHR_THR) & ~dlab;
            new_baud <= wr_commit & dlab & (awaddr[2:1] == 2'b00);
        end
    end

    // read data channel; data is captured at address accept and held until rready
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rd_en  <= 1'b0;
        end else begin
            rvalid <= ar_acc | (rvalid & ~rready);
            rdata  <= ar_acc ? {24'b0, rbyte} : rdata;
            rd_en  <= ar_acc & (araddr[2:0] == ADDR_RHR_THR) & ~dlab & rx_ready;
        end
    end
endmodule

// File: tb/tb_axi_ui.sv
// tb_axi_ui: table-driven, directed and randomized checks of axi_ui against a register-level model
module tb_axi_ui;
    import axi4_lite_pkg::*;
    import uart_16550_regs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    axi_lite_addr_t awaddr, araddr;
    axi_lite_data_t wdata, rdata;
    axi_lite_strb_t wstrb;
    axi_lite_resp_t bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    uart_16550_regs_t regs_out;
    logic wr_en, rd_en, new_baud, irq, irq_n;
    logic tx_ready, rx_ready, parity_err, framing_err, overrun_err;
    logic [7:0] rd_data;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    axi_ui dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out), .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data),
        .tx_ready(tx_ready), .rx_ready(rx_ready),
        .parity_err(parity_err), .framing_err(framing_err), .overrun_err(overrun_err),
        .new_baud(new_baud), .irq(irq), .irq_n(irq_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: plain register variables updated from the register map rules
    logic [7:0] m_ier, m_fcr, m_lcr, m_mcr, m_spr, m_dll, m_dlm;

    task automatic m_reset();
        m_ier = 8'h00; m_fcr = 8'h00; m_lcr = 8'h03; m_mcr = 8'h00;
        m_spr = 8'h00; m_dll = 8'h01; m_dlm = 8'h00;
    endtask

    function automatic logic [7:0] m_isr();
        if (m_ier[2] && (parity_err || framing_err || overrun_err)) return 8'h0C;
        if (m_ier[0] && rx_ready) return 8'h08;
        if (m_ier[1] && tx_ready) return 8'h04;
        return 8'h03;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic dl = m_lcr[7];
        case (a)
            3'd0: return dl ? m_dll : rd_data;
            3'd1: return dl ? m_dlm : m_ier;
            3'd2: return m_isr();
            3'd3: return m_lcr;
            3'd4: return m_mcr;
            3'd5: return {1'b0, tx_ready, tx_ready, 1'b0, framing_err, parity_err, overrun_err, rx_ready};
            3'd6: return 8'h00;
            default: return m_spr;
        endcase
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [7:0] d, input logic s);
        logic dl = m_lcr[7];
        if (s) begin
            case (a)
                3'd0: if (dl) m_dll = d;
                3'd1: if (dl) m_dlm = d; else m_ier = {5'b0, d[2:0]};
                3'd2: m_fcr = d;
                3'd3: m_lcr = d;
                3'd4: m_mcr = d;
                3'd7: m_spr = d;
                default: ;
            endcase
        end
    endtask

    // full write transaction; reports strobes in the first bvalid cycle and one cycle later
    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic s,
                            output logic p_wr, output logic p_nb, output logic p_late);
        int n = 0;
        awaddr = {29'($urandom()), a};
        wdata  = {24'($urandom()), d};
        wstrb  = {3'($urandom()), s};
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        chk("aw_w_ready", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_rise", bvalid, 1'b1);
        chk("bresp", bresp, 2'b00);
        p_wr = wr_en; p_nb = new_baud;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        p_late = wr_en | new_baud;
        chk("bvalid_drop", bvalid, 1'b0);
    endtask

    // full read transaction; reports data and rd_en in the first rvalid cycle and one cycle later
    task automatic do_read(input logic [2:0] a, output logic [31:0] d,
                           output logic p_rd, output logic p_late);
        int n = 0;
        araddr = {29'($urandom()), a};
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("arready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_rise", rvalid, 1'b1);
        chk("rresp", rresp, 2'b00);
        d = rdata; p_rd = rd_en;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        p_late = rd_en;
        chk("rvalid_drop", rvalid, 1'b0);
    endtask

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic       s;
        logic [7:0] rb;
        logic       wr;
        logic       nb;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic p_wr, p_nb, p_rd, p_late;
        uart_16550_regs_t e_rst;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        tx_ready = 1'b0; rx_ready = 1'b0; parity_err = 1'b0; framing_err = 1'b0;
        overrun_err = 1'b0; rd_data = 8'h5A;

        // reset holds every handshake low even with valids asserted
        rst = 1'b0; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_strobes", {wr_en, rd_en, new_baud}, 3'b000);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e_rst = '{ier: 8'h00, fcr: 8'h00, lcr: 8'h03, mcr: 8'h00, spr: 8'h00, dl: 16'h0001, psd: 4'h0};
        chk("rst_regs", regs_out, e_rst);
        chk("rst_irq", {irq, irq_n}, 2'b01);
        rst = 1'b1; m_reset();
        @(posedge clk); #1;

        // post-reset readback of LCR and the DLL through DLAB
        do_read(3'd3, d, p_rd, p_late);
        chk("rst_lcr_read", d, 32'h03);
        do_write(3'd3, 8'h83, 1'b1, p_wr, p_nb, p_late); m_write(3'd3, 8'h83, 1'b1);
        do_read(3'd0, d, p_rd, p_late);
        chk("rst_dll_read", d, 32'h01);

        tbl[0]  = '{3'd3, 8'h83, 1'b1, 8'h83, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 8'hAA, 1'b1, 8'hAA, 1'b0, 1'b1};
        tbl[2]  = '{3'd1, 8'h55, 1'b1, 8'h55, 1'b0, 1'b1};
        tbl[3]  = '{3'd0, 8'h11, 1'b0, 8'hAA, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 8'h03, 1'b1, 8'h03, 1'b0, 1'b0};
        tbl[5]  = '{3'd0, 8'hAB, 1'b1, 8'h5A, 1'b1, 1'b0};
        tbl[6]  = '{3'd1, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[7]  = '{3'd4, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[8]  = '{3'd7, 8'hC3, 1'b1, 8'hC3, 1'b0, 1'b0};
        tbl[9]  = '{3'd5, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{3'd6, 8'h12, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{3'd2, 8'hC1, 1'b1, 8'h03, 1'b0, 1'b0};
        tbl[12] = '{3'd1, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            do_write(tbl[i].a, tbl[i].d, tbl[i].s, p_wr, p_nb, p_late);
            m_write(tbl[i].a, tbl[i].d, tbl[i].s);
            chk($sformatf("tbl%0d_wr_en", i), p_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_new_baud", i), p_nb, tbl[i].nb);
            chk($sformatf("tbl%0d_strobe_len", i), p_late, 1'b0);
            do_read(tbl[i].a, d, p_rd, p_late);
            chk($sformatf("tbl%0d_readback", i), d, {24'h0, tbl[i].rb});
            chk($sformatf("tbl%0d_rd_en", i), p_rd, 1'b0);
        end
        chk("regs_fcr", regs_out.fcr, 8'hC1);
        chk("regs_dl", regs_out.dl, 16'h55AA);
        chk("regs_ier_lcr", {regs_out.ier, regs_out.lcr}, 16'h0703);
        chk("regs_mcr_spr", {regs_out.mcr, regs_out.spr}, 16'h3CC3);

        // RX interrupt and RHR pop
        rx_ready = 1'b1; rd_data = 8'hAB; #1;
        chk("irq_rx", {irq, irq_n}, 2'b10);
        do_read(3'd0, d, p_rd, p_late);
        chk("rhr_data", d, 32'hAB);
        chk("rhr_rd_en", p_rd, 1'b1);
        chk("rhr_rd_en_len", p_late, 1'b0);
        rx_ready = 1'b0; #1;
        chk("irq_n_idle", irq_n, 1'b1);

        // ISR priority
        parity_err = 1'b1; rx_ready = 1'b1; tx_ready = 1'b1;
        do_read(3'd2, d, p_rd, p_late); chk("isr_ls", d, 32'h0C);
        parity_err = 1'b0; tx_ready = 1'b0;
        do_read(3'd2, d, p_rd, p_late); chk("isr_rx", d, 32'h08);
        rx_ready = 1'b0; tx_ready = 1'b1;
        do_read(3'd2, d, p_rd, p_late); chk("isr_tx", d, 32'h04);
        framing_err = 1'b1;
        do_read(3'd5, d, p_rd, p_late); chk("lsr_mixed", d, 32'h68);
        framing_err = 1'b0; tx_ready = 1'b0;
        do_read(3'd2, d, p_rd, p_late); chk("isr_none", d, 32'h03);

        // simultaneous read and write of SPR: read sees the value before the write
        araddr = 32'h7; arvalid = 1'b1;
        awaddr = 32'h7; wdata = 32'h5E; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("simul_readies", {awready, arready}, 2'b11);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("simul_valids", {bvalid, rvalid}, 2'b11);
        chk("simul_rdata", rdata, {24'h0, m_read(3'd7)});
        m_write(3'd7, 8'h5E, 1'b1);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(3'd7, d, p_rd, p_late); chk("simul_spr", d, 32'h5E);

        // reset aborts pending responses
        awaddr = 32'h4; wdata = 32'h99; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h3; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("abort_pending", {bvalid, rvalid}, 2'b11);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_valids", {bvalid, rvalid}, 2'b00);
        chk("abort_rdata", rdata, 32'h0);
        rst = 1'b1; m_reset();
        @(posedge clk); #1;
        chk("abort_stays", {bvalid, rvalid}, 2'b00);
        chk("abort_regs", regs_out, e_rst);

        // randomized traffic against the model
        for (int i = 0; i < 120; i++) begin
            logic [2:0] a;
            logic [7:0] wd, exp;
            logic s, ew, en, er;
            a = 3'($urandom_range(0, 7));
            wd = 8'($urandom());
            s = ($urandom_range(0, 3) != 0);
            rx_ready = 1'($urandom()); tx_ready = 1'($urandom());
            parity_err = ($urandom_range(0, 7) == 0);
            framing_err = ($urandom_range(0, 7) == 0);
            overrun_err = ($urandom_range(0, 7) == 0);
            rd_data = 8'($urandom());
            #1;
            chk($sformatf("rnd%0d_irq", i), {irq, irq_n}, {m_isr() != 8'h03, m_isr() == 8'h03});
            if ($urandom_range(0, 1) == 0) begin
                exp = m_read(a);
                er = (a == 3'd0) && !m_lcr[7] && rx_ready;
                do_read(a, d, p_rd, p_late);
                chk($sformatf("rnd%0d_rdata_a%0d", i, a), d, {24'h0, exp});
                chk($sformatf("rnd%0d_rd_en", i), {p_rd, p_late}, {er, 1'b0});
            end else begin
                ew = s && (a == 3'd0) && !m_lcr[7];
                en = s && (a <= 3'd1) && m_lcr[7];
                do_write(a, wd, s, p_wr, p_nb, p_late);
                m_write(a, wd, s);
                chk($sformatf("rnd%0d_wstrobes_a%0d", i, a), {p_wr, p_nb, p_late}, {ew, en, 1'b0});
            end
        end
        chk("rnd_final_dl", regs_out.dl, {m_dlm, m_dll});
        chk("rnd_final_regs", {regs_out.ier, regs_out.fcr, regs_out.lcr, regs_out.mcr, regs_out.spr},
            {m_ier, m_fcr, m_lcr, m_mcr, m_spr});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axi_ui.md
AXI_UI -- requirements
Module: axi_ui

Interface
REQ-001 Parameters SHALL be:
- DL_WIDTH, 16, divisor latch width {DLM,DLL}.
- PSD_WIDTH, 4, prescaler field width carried in regs_out.
- FIFO_DEPTH, 16, informational only; no functional effect.

REQ-002 One clock; reset is synchronous and active-low. Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- awaddr  in  axi_lite_addr_t(32)  write address; only [2:0] decoded.
- awvalid  in  1 / awready  out  1  write-address handshake.
- wdata  in  axi_lite_data_t(32)  write data; [7:0] used.
- wstrb  in  axi_lite_strb_t(4)  byte strobes; only [0] used.
- wvalid  in  1 / wready  out  1  write-data handshake.
- bvalid  out  1 / bresp  out  2 / bready  in  1  write response.
- araddr  in  32 / arvalid  in  1 / arready  out  1  read address.
- rdata  out  32 / rresp  out  2 / rvalid  out  1 / rready  in  1  read data.
- regs_out  out  uart_16550_regs_t  all stored registers.
- wr_en  out  1  THR push strobe.
- rd_en  out  1  RHR pop strobe.
- rd_data  in  8  RX FIFO head byte.
- tx_ready  in  1  THR/TX empty.
- rx_ready  in  1  RX data available.
- parity_err, framing_err, overrun_err  in  1 each  line errors.
- new_baud  out  1  divisor-changed strobe.
- irq  out  1  active-high interrupt.
- irq_n  out  1  always ~irq.

Function
REQ-003 awready and wready SHALL assert together for one cycle when awvalid && wvalid && !bvalid; the write commits in that cycle.
REQ-004 bvalid SHALL rise the cycle after write accept and hold until bready; bresp = 2'b00 (OKAY).
REQ-005 arready SHALL pulse for one cycle when arvalid && !rvalid; rdata is registered at accept.
REQ-006 rvalid SHALL rise the next cycle and hold until rready; rresp = OKAY; rdata[31:8] = 0.
REQ-007 A simultaneous read and write SHALL be handled independently.
REQ-008 Register writes SHALL be ignored when wstrb[0] = 0; the B response is still issued.
REQ-009 Register map by addr[2:0] (DLAB = LCR[7]):
- 0: DLAB=0 read RHR (rd_data), write THR; DLAB=1 DLL.
- 1: DLAB=0 IER (bits [2:0] used); DLAB=1 DLM.
- 2: read ISR, write FCR.
- 3: LCR.
- 4: MCR.
- 5: LSR, read-only.
- 6: MSR, reads 0.
- 7: SPR.
REQ-010 LSR read value SHALL be {1'b0, tx_ready, tx_ready, 1'b0, framing_err, parity_err, overrun_err, rx_ready}.
REQ-011 Interrupt sources SHALL be level-sensitive and combinational from live inputs, not latched:
- LS = IER[2] & (parity_err | framing_err | overrun_err).
- RX = IER[0] & rx_ready.
- TX = IER[1] & tx_ready.
REQ-012 ISR SHALL read {3'b000, code}; priority LS > RX > TX; code: LS 5'h0C, RX 5'h08, TX 5'h04, none 5'h03.
REQ-013 irq SHALL be the combinational OR of LS, RX and TX; irq_n = ~irq.
REQ-014 wr_en SHALL be a one-cycle pulse, coincident with the first bvalid cycle, for a committed THR write (addr 0, DLAB=0).
REQ-015 new_baud SHALL pulse with the same timing for a committed DLL or DLM write (DLAB=1).
REQ-016 rd_en SHALL pulse for one cycle, coincident with the first rvalid cycle, for an RHR read with DLAB=0 and rx_ready=1; no pulse otherwise.
REQ-017 regs_out SHALL reflect stored register values one cycle after commit.

Reset
REQ-018 While rst=0 at a clk edge, registers SHALL take: IER 0, LCR 8'h03, DLL 8'h01, DLM 8'h00, FCR 0, MCR 0, SPR 0.
REQ-019 While rst=0 at a clk edge, outputs SHALL take: all ready/valid 0, rdata 0, wr_en/rd_en/new_baud 0.
REQ-020 Reset mid-transaction SHALL abort any pending B or R response without issuing it.

Structure
REQ-021 axi4_lite_pkg SHALL hold axi_lite_addr_t/data_t(32), strb_t(4), resp_t(2) and the OKAY constant.
REQ-022 uart_16550_regs_pkg SHALL hold uart_16550_regs_t, the register address constants and the ISR code constants.
REQ-023 The interrupt priority encoder SHALL be one sub-module, uart_irq_ctrl; all else lives in axi_ui.

Verification
REQ-024 After reset, reads SHALL return: LCR → 0x03; with LCR=0x83, addr 0 → 0x01 (DLL).
REQ-025 With DLAB=1: write 0xAA to addr 0 → readback 0xAA; write 0x55 to addr 1 → readback 0x55; new_baud pulses on each write.
REQ-026 LCR=0x03, write 0xAB to addr 0 → wr_en pulses exactly one cycle.
REQ-027 IER=0x07 and rx_ready=1 → irq=1; addr-0 read returns rd_data 0xAB with one rd_en pulse; rx_ready=0 → irq_n=1.
REQ-028 IER=0x07, ISR reads SHALL give: parity_err=1 → 0x0C; rx_ready only → 0x08; tx_ready only → 0x04; none → 0x03.
